// File: rtl/transposer_feeder_pkg.sv
// Shared definitions for the transposer feeder and its transposer.
// Holds the feeder state encoding and the supported precisions.
package transposer_feeder_pkg;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        STREAM,
        DRAIN
    } feeder_state_e;

    localparam logic [31:0] PREC_2  = 32'd2;
    localparam logic [31:0] PREC_4  = 32'd4;
    localparam logic [31:0] PREC_8  = 32'd8;
    localparam logic [31:0] PREC_16 = 32'd16;

    function automatic logic prec_ok(input logic [31:0] p);
        return (p == PREC_2) || (p == PREC_4) ||
               (p == PREC_8) || (p == PREC_16);
    endfunction

endpackage

// File: rtl/feeder_buf.sv
// Block buffer for the transposer feeder.
// Simple dual-port memory with a registered read that clears when idle.
module feeder_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register doubles as the streamed word, so it reads 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/transposer_feeder.sv
// Collects one block of packed words, then launches and streams it
// into the transposer once the transposer is free.
import transposer_feeder_pkg::*;

module transposer_feeder #(
    parameter int XLEN          = 32,
    parameter int NUM_WORDS     = 64,
    parameter int MAX_DATA_PREC = 16,
    parameter int BUF_DEPTH     = NUM_WORDS * MAX_DATA_PREC / XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_word,
    input  logic [31:0]     in_prec,
    input  logic [31:0]     in_baddr,
    input  logic            tr_busy,
    output logic            out_start,
    output logic [31:0]     out_prec,
    output logic [31:0]     out_baddr,
    output logic [XLEN-1:0] out_word,
    output logic            err_prec
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    function automatic logic [PTR_W-1:0] len_m1(input logic [31:0] p);
        logic [31:0] l;
        l = (p * 32'(NUM_WORDS)) / 32'(XLEN) - 32'd1;
        return l[PTR_W-1:0];
    endfunction

    feeder_state_e    state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_addr;
    logic [PTR_W-1:0] fill_last;
    logic [31:0]      prec_q, baddr_q;
    logic             in_ready_q, err_q, seen_q;
    logic             xfer, first, good, wr_en, rd_en, start;

    assign xfer      = in_valid && in_ready_q;
    assign first     = (wr_ptr_q == '0);
    assign good      = prec_ok(in_prec);
    assign wr_en     = xfer && (!first || good);
    assign fill_last = first ? len_m1(in_prec) : len_m1(prec_q);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = rd_ptr_q;
        unique case (state_q)
            FILL: begin
                if (wr_en && (wr_ptr_q == fill_last)) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!tr_busy) begin
                    start   = 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (rd_ptr_q != len_m1(prec_q)) begin
                    rd_en   = 1'b1;
                    rd_addr = rd_ptr_q + 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (seen_q && !tr_busy) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            prec_q     <= '0;
            baddr_q    <= '0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == FILL);
            err_q      <= xfer && first && !good;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end else if (state_q == DRAIN && state_d == FILL) begin
                wr_ptr_q <= '0;
            end
            if (wr_en && first) begin
                prec_q  <= in_prec;
                baddr_q <= in_baddr;
            end
            if (start) begin
                rd_ptr_q <= '0;
            end else if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Busy must be seen high inside DRAIN before its fall counts.
            if (state_q != DRAIN) begin
                seen_q <= 1'b0;
            end else if (tr_busy) begin
                seen_q <= 1'b1;
            end
        end
    end

    feeder_buf #(
        .XLEN  (XLEN),
        .DEPTH (BUF_DEPTH),
        .AW    (PTR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (in_word),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (out_word)
    );

    assign in_ready  = in_ready_q;
    assign out_start = start;
    assign out_prec  = prec_q;
    assign out_baddr = baddr_q;
    assign err_prec  = err_q;

endmodule

// File: tb/tb_transposer_feeder.sv
// Randomized bench for transposer_feeder with a queue-based block model.
module tb_transposer_feeder;

    localparam int XLEN      = 32;
    localparam int NUM_WORDS = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_word = '0;
    logic [31:0]     in_prec = '0;
    logic [31:0]     in_baddr = '0;
    logic            tr_busy;
    logic            out_start;
    logic [31:0]     out_prec;
    logic [31:0]     out_baddr;
    logic [XLEN-1:0] out_word;
    logic            err_prec;

    logic hold_busy = 1'b0;
    logic auto_busy = 1'b0;
    assign tr_busy = hold_busy | auto_busy;

    always #5 clk = ~clk;

    transposer_feeder #(
        .XLEN      (XLEN),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_prec   (in_prec),
        .in_baddr  (in_baddr),
        .tr_busy   (tr_busy),
        .out_start (out_start),
        .out_prec  (out_prec),
        .out_baddr (out_baddr),
        .out_word  (out_word),
        .err_prec  (err_prec)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic int len_of(input int p);
        return NUM_WORDS * p / XLEN;
    endfunction

    function automatic bit ok_prec(input int p);
        return p == 2 || p == 4 || p == 8 || p == 16;
    endfunction

    // Block-level model: words queue up, launch when transposer is free,
    // stream back in order, then wait for a busy pulse to complete.
    int          q_fill[$];
    int          q_stream[$];
    int          mon_words[$];
    int          blk_len = 0;
    bit          launch_pend = 0, streaming = 0, draining = 0;
    bit          seen = 0, err_nxt = 0, up = 0;
    logic [31:0] held_prec = '0, held_baddr = '0, cur_word = '0;
    int          start_cnt = 0, err_cnt = 0;

    always @(negedge clk) begin : cmp
        bit fill_ph, exp_ready, exp_start;
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_start", out_start, 0);
            check("rst_out_word", out_word, 0);
            check("rst_out_prec", out_prec, 0);
            check("rst_out_baddr", out_baddr, 0);
            check("rst_err_prec", err_prec, 0);
            q_fill.delete();
            q_stream.delete();
            launch_pend = 0;
            streaming = 0;
            draining = 0;
            seen = 0;
            err_nxt = 0;
            up = 0;
            held_prec = '0;
            held_baddr = '0;
            cur_word = '0;
        end else begin
            fill_ph   = !launch_pend && !streaming && !draining;
            exp_ready = up && fill_ph;
            exp_start = launch_pend && !tr_busy;
            check("in_ready", in_ready, exp_ready);
            check("out_start", out_start, exp_start);
            check("out_word", out_word, cur_word);
            check("err_prec", err_prec, err_nxt);
            check("out_prec", out_prec, held_prec);
            check("out_baddr", out_baddr, held_baddr);
            if (out_start) start_cnt++;
            if (err_prec) err_cnt++;
            if (streaming) mon_words.push_back(int'(out_word));
            err_nxt = 0;
            if (streaming) begin
                if (q_stream.size() > 0) begin
                    cur_word = q_stream.pop_front();
                end else begin
                    cur_word = '0;
                    streaming = 0;
                    draining = 1;
                    seen = 0;
                end
            end else if (draining) begin
                if (seen && !tr_busy) draining = 0;
                else if (tr_busy) seen = 1;
            end
            if (exp_ready && in_valid) begin
                if (q_fill.size() == 0) begin
                    if (ok_prec(int'(in_prec))) begin
                        held_prec  = in_prec;
                        held_baddr = in_baddr;
                        blk_len    = len_of(int'(in_prec));
                        q_fill.push_back(int'(in_word));
                    end else begin
                        err_nxt = 1;
                    end
                end else begin
                    q_fill.push_back(int'(in_word));
                end
                if (q_fill.size() > 0 && q_fill.size() == blk_len)
                    launch_pend = 1;
            end
            if (exp_start) begin
                q_stream = q_fill;
                q_fill.delete();
                launch_pend = 0;
                streaming = 1;
                cur_word = q_stream.pop_front();
            end
            up = 1;
        end
    end

    // Transposer stand-in: pulses busy a little after each stream ends.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_start) begin
                int l;
                l = len_of(int'(out_prec));
                repeat (l + 2) @(posedge clk);
                #1 auto_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 auto_busy = 1'b0;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input logic [31:0] p,
                             input logic [31:0] b);
        in_valid = 1'b1;
        in_word  = w;
        in_prec  = p;
        in_baddr = b;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t >= 300) begin
                timeout("send_word");
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_block(input int p, input logic [31:0] b,
                              input int n, input bit gap, input bit seq);
        for (int i = 0; i < n; i++) begin
            send_word(seq ? 32'(i) : $urandom,
                      (i == 0) ? 32'(p) : $urandom,
                      (i == 0) ? b : $urandom);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t >= 400) begin
                timeout("wait_idle");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        bool_loop: begin end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sequential prec=8 block with literal latency and data.
        mon_words.delete();
        send_block(8, 32'h100, 16, 0, 1);
        @(negedge clk);
        check("start_latency", out_start, 1);
        @(posedge clk);
        #1;
        wait_idle();
        check("p8_count", mon_words.size(), 16);
        for (int i = 0; i < 16 && i < mon_words.size(); i++)
            check("p8_word", mon_words[i], i);
        check("p8_baddr", out_baddr, 32'h100);

        // Launch held off by a busy transposer.
        hold_busy = 1'b1;
        st = start_cnt;
        send_block(16, 32'h2000, 32, 0, 0);
        repeat (10) @(posedge clk);
        check("held_no_start", start_cnt, st);
        #1 hold_busy = 1'b0;
        @(negedge clk);
        check("start_after_busy", out_start, 1);
        mon_words.delete();
        @(posedge clk);
        #1;
        wait_idle();
        check("p16_count", mon_words.size(), 32);

        // Rejected precision, then a small valid block.
        st = err_cnt;
        send_word(32'hAA, 32'd3, 32'h40);
        @(negedge clk);
        check("err_pulse", err_prec, 1);
        check("err_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send_block(2, 32'h44, 4, 0, 1);
        wait_idle();
        check("err_cnt", err_cnt - st, 1);
        check("p2_prec", out_prec, 2);

        // Gapped input, prec=4.
        mon_words.delete();
        send_block(4, 32'h200, 8, 1, 1);
        wait_idle();
        check("gap_count", mon_words.size(), 8);
        for (int i = 0; i < 8 && i < mon_words.size(); i++)
            check("gap_word", mon_words[i], i);

        // Reset during stream word 5.
        send_block(8, 32'h300, 16, 0, 1);
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (out_start) break;
            if (t >= 50) begin
                timeout("rst_wait_start");
                break;
            end
        end
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_word", out_word, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        st = start_cnt;
        send_block(8, 32'h380, 15, 0, 1);
        repeat (3) @(posedge clk);
        check("rst_no_start", start_cnt, st);
        #1;
        send_word(32'd15, $urandom, $urandom);
        @(negedge clk);
        check("rst_refill_start", out_start, 1);
        @(posedge clk);
        #1;
        wait_idle();

        // Back-to-back blocks.
        send_block(2, 32'h500, 4, 0, 0);
        send_block(16, 32'h600, 32, 0, 0);
        wait_idle();
        check("b2b_prec", out_prec, 16);

        // Random blocks.
        for (int k = 0; k < 20; k++) begin
            int p;
            p = 2 << $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0)
                send_word($urandom, 32'($urandom_range(17, 99)), $urandom);
            send_block(p, $urandom, len_of(p), 1'($urandom_range(0, 1)), 0);
        end
        wait_idle();
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
